// File: rtl/seq_count_pkg.sv
// Shared types for the sequenced counter controller.
// Holds the FSM state encoding used by the controller, its interface and the bench.
package seq_count_pkg;

    // state output is two bits wide; encoding 3 is never produced
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/seq_count_if.sv
// Control/status bundle between a requester and seq_count_ctrl.
// master: drives start, x, abort, limit; slave: drives count, state, busy, done, aborted.
interface seq_count_if #(
    parameter int WIDTH = 4
);
    import seq_count_pkg::*;

    logic             start;
    logic             x;
    logic             abort;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    state_t           state;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start,
        output x,
        output abort,
        output limit,
        input  count,
        input  state,
        input  busy,
        input  done,
        input  aborted
    );

    modport slave (
        input  start,
        input  x,
        input  abort,
        input  limit,
        output count,
        output state,
        output busy,
        output done,
        output aborted
    );

endinterface

// File: rtl/seq_count_cnt.sv
// WIDTH-bit up counter with synchronous clear and count enable, wrapping modulo 2^WIDTH.
// Ports: clk, reset (sync, active-high), clr_i (clear, wins over en_i), en_i, count_o.
module seq_count_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_count_ctrl.sv
// Sequenced count controller: IDLE -> ARM -> RUN, counting qualified x cycles up to a
// captured limit. Ports: clk, reset (sync, active-high), bus (seq_count_if.slave).
module seq_count_ctrl
    import seq_count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    seq_count_if.slave     bus
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] lim_d;
    logic             done_q;
    logic             done_d;
    logic             aborted_q;
    logic             aborted_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             lim_ld;
    logic [WIDTH-1:0] count;
    logic             term;

    seq_count_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (count)
    );

    // Terminal match uses the registered count; only consulted in RUN
    assign term  = (count == lim_q);
    assign lim_d = lim_ld ? bus.limit : lim_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lim_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lim_q     <= lim_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.x) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort || term) begin
                    state_d = IDLE;
                end else if (!bus.x) begin
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        lim_ld    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_clr = 1'b1;
                    lim_ld  = 1'b1;
                end
            end
            ARM: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end else if (bus.x) begin
                    cnt_en = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end else if (term) begin
                    done_d = 1'b1;
                end else if (bus.x) begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b0;
            end
        endcase
    end

    assign bus.count   = count;
    assign bus.state   = state_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;

endmodule
